// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, FSM states and a small helper shared by the sequential ALU.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SRL  = 4'b0100,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_MULU = 4'b1000,
        OP_DIVU = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // Signed less-than on the sign bits and unsigned magnitude; exact even when a-b overflows.
    function automatic logic slt_signed(input logic sa, input logic sb, input logic ult);
        return (sa != sb) ? sa : ult;
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: shared iterative datapath, shift-add multiply and (ALU_SEQ_DIV_EN) restoring divide.
// Latency: loads on i_start, then one step per cycle for WIDTH cycles; o_done flags the final step.
// Backpressure: none; after the last step the registers hold until the next i_start.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
`ifdef ALU_SEQ_DIV_EN
    input  logic             i_div,
`endif
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo_nxt,
    output logic [WIDTH-1:0] o_hi_nxt
);

    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_add;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH-1:0] w_mul_hi;

    // Multiply step: add multiplicand into the high half when the multiplier LSB is set, then shift right.
    always_comb begin
        w_add    = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_b}) : {1'b0, r_hi};
        w_mul_hi = w_add[WIDTH:1];
        w_mul_lo = {w_add[0], r_lo[WIDTH-1:1]};
    end

`ifdef ALU_SEQ_DIV_EN
    logic             r_div;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_div_lo;
    logic [WIDTH-1:0] w_div_hi;

    // Divide step: shift the next dividend bit into the remainder, subtract the divisor if it fits.
    always_comb begin
        w_shift  = {r_hi, r_lo[WIDTH-1]};
        w_ge     = (w_shift >= {1'b0, r_b});
        w_div_hi = w_ge ? (w_shift[WIDTH-1:0] - r_b) : w_shift[WIDTH-1:0];
        w_div_lo = {r_lo[WIDTH-2:0], w_ge};
    end

    // Remember which operation is iterating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= 1'b0;
        end else if (i_start) begin
            r_div <= i_div;
        end
    end

    assign o_lo_nxt = r_div ? w_div_lo : w_mul_lo;
    assign o_hi_nxt = r_div ? w_div_hi : w_mul_hi;
`else
    assign o_lo_nxt = w_mul_lo;
    assign o_hi_nxt = w_mul_hi;
`endif

    // The step that takes the counter from 1 to 0 is the last one.
    assign o_done = (r_cnt == CNT_W'(1));

    // Load operands on start, otherwise step while iterations remain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo  <= '0;
            r_hi  <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_lo  <= i_a;
            r_hi  <= '0;
            r_b   <= i_b;
            r_cnt <= CNT_W'(WIDTH);
        end else if (r_cnt != '0) begin
            r_lo  <= o_lo_nxt;
            r_hi  <= o_hi_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU, single-cycle logic/arith ops, iterative MULU, DIVU when ALU_SEQ_DIV_EN is defined.
// Latency: simple, illegal and divide-by-zero results valid the cycle after accept; MULU/DIVU after WIDTH busy cycles.
// Backpressure: result held in DONE until out_ready; in_ready low in BUSY and DONE.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zout,
    output logic             dz,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zout;
    logic             r_dz;
    logic             r_illegal;

    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_res_hi;
    logic             w_dz;
    logic             w_illegal;
    logic             w_iter_op;
    logic             w_div;
    logic             w_start;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] w_hi_nxt;
    logic             w_ult;

    assign w_ult = (a < b);

    // Decode the op: single-cycle results, or a request for the iterative datapath.
    always_comb begin
        w_res     = '0;
        w_res_hi  = '0;
        w_dz      = 1'b0;
        w_illegal = 1'b0;
        w_iter_op = 1'b0;
        w_div     = 1'b0;
        case (op)
            OP_ADD:  w_res = a + b;
            OP_SUB:  w_res = a - b;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, slt_signed(a[WIDTH-1], b[WIDTH-1], w_ult)};
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_SRL:  w_res = a >> b[SHW-1:0];
            OP_MULU: w_iter_op = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU: begin
                if (b == '0) begin
                    w_res    = '1;
                    w_res_hi = a;
                    w_dz     = 1'b1;
                end else begin
                    w_iter_op = 1'b1;
                    w_div     = 1'b1;
                end
            end
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_start = (r_state == IDLE) && in_valid && w_iter_op;

    alu_seq_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
`ifdef ALU_SEQ_DIV_EN
        .i_div    (w_div),
`endif
        .i_a      (a),
        .i_b      (b),
        .o_done   (w_iter_done),
        .o_lo_nxt (w_lo_nxt),
        .o_hi_nxt (w_hi_nxt)
    );

`ifndef ALU_SEQ_DIV_EN
    logic w_div_unused;
    assign w_div_unused = w_div;
`endif

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zout      <= 1'b1;
            r_dz        <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dz      <= 1'b0;
                        r_illegal <= 1'b0;
                        if (w_iter_op) begin
                            r_state <= BUSY;
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_result_hi <= w_res_hi;
                            r_zout      <= (w_res == '0);
                            r_dz        <= w_dz;
                            r_illegal   <= w_illegal;
                        end
                    end
                end
                BUSY: begin
                    if (w_iter_done) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_lo_nxt;
                        r_result_hi <= w_hi_nxt;
                        r_zout      <= (w_lo_nxt == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zout      = r_zout;
    assign dz        = r_dz;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model.
// Latency: measured in clock edges from the accepting edge to the first out_valid.
// Backpressure: exercises held out_ready, back-to-back accepts and mid-operation reset.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zout;
    logic         dz;
    logic         illegal;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zout      (zout),
        .dz        (dz),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Reference behaviour from the op definitions; latency counts edges from accept to out_valid.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] er, output logic [W-1:0] eh,
                                  output logic edz, output logic eill, output int elat);
        logic [2*W-1:0] p;
        er = '0; eh = '0; edz = 1'b0; eill = 1'b0; elat = 1;
        case (o)
            4'b0010: er = x + y;
            4'b0110: er = x - y;
            4'b0111: er = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b0000: er = x & y;
            4'b0001: er = x | y;
            4'b0100: er = x >> (y % W);
            4'b1000: begin
                p = {32'd0, x} * {32'd0, y};
                er = p[W-1:0]; eh = p[2*W-1:W]; elat = W + 1;
            end
            4'b1001: begin
`ifdef ALU_SEQ_DIV_EN
                if (y == 0) begin er = '1; eh = x; edz = 1'b1; end
                else begin er = x / y; eh = x % y; elat = W + 1; end
`else
                eill = 1'b1;
`endif
            end
            default: eill = 1'b1;
        endcase
    endfunction

    // Present one op, wait for acceptance, optionally scramble inputs, then count edges to out_valid.
    task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit scramble, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        if (scramble) begin
            a = $urandom; b = $urandom; op = 4'($urandom);
        end
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic drain();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, result, result_hi, dz, illegal, zout} !== {1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_outputs: got vld=%b res=%h hi=%h dz=%b ill=%b z=%b, want 0/0/0/0/0/1",
                     out_valid, result, result_hi, dz, illegal, zout);
        end
        @(negedge clk); rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [3:0]   ops [7];
        logic [W-1:0] xs  [7];
        logic [W-1:0] ys  [7];
        logic [W-1:0] er, eh;
        logic edz, eill;
        int elat, lat;
        ops = '{4'b0010, 4'b0111, 4'b0111, 4'b1000, 4'b1001, 4'b1001, 4'b1111};
        xs  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd5, 32'h1234_5678};
        ys  = '{32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'd2, 32'd7, 32'd0, 32'h9ABC_DEF0};
        for (int i = 0; i < 7; i++) begin
            model(ops[i], xs[i], ys[i], er, eh, edz, eill, elat);
            do_op(ops[i], xs[i], ys[i], 1'b1, lat);
            n_cmp++;
            if (lat !== elat) begin
                n_err++; $display("FAIL dir%0d_latency op=%b: got %0d want %0d", i, ops[i], lat, elat);
            end
            n_cmp++;
            if ({result, result_hi, dz, illegal, zout} !== {er, eh, edz, eill, (er == 0)}) begin
                n_err++;
                $display("FAIL dir%0d_result op=%b: got res=%h hi=%h dz=%b ill=%b z=%b want res=%h hi=%h dz=%b ill=%b z=%b",
                         i, ops[i], result, result_hi, dz, illegal, zout, er, eh, edz, eill, (er == 0));
            end
            drain();
        end
        // Fixed values independent of the model for the headline cases.
        do_op(4'b1000, 32'hFFFF_FFFF, 32'd2, 1'b0, lat);
        n_cmp++;
        if ({result_hi, result} !== 64'h0000_0001_FFFF_FFFE || lat !== 33) begin
            n_err++; $display("FAIL mulu_const: got %h_%h lat %0d want 00000001_fffffffe lat 33", result_hi, result, lat);
        end
        drain();
        do_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0, lat);
        n_cmp++;
        if ({result, zout, illegal, lat} !== {32'd0, 1'b1, 1'b0, 32'd1}) begin
            n_err++; $display("FAIL add_wrap: got res=%h z=%b ill=%b lat=%0d want 0/1/0/1", result, zout, illegal, lat);
        end
        drain();
    endtask

    task automatic test_hold();
        int lat;
        logic [W-1:0] held;
        do_op(4'b0001, 32'h00F0_0F00, 32'h0000_00FF, 1'b0, lat);
        held = result;
        @(negedge clk);
        in_valid = 1'b1; op = 4'b0110; a = 32'd9; b = 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'h00F0_0FFF} || held !== 32'h00F0_0FFF) begin
                n_err++;
                $display("FAIL hold_cycle%0d: got vld=%b rdy=%b res=%h want 1/0/00f00fff", i, out_valid, in_ready, result);
            end
        end
        @(negedge clk); out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1; out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL hold_release: got vld=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_no_accept: got vld=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   simple [6];
        logic [W-1:0] qr [$];
        logic [W-1:0] er, eh, exp_r;
        logic edz, eill, acc, prev_vld;
        int elat, nres;
        simple = '{4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0001, 4'b0100};
        nres = 0; prev_vld = 1'b0;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        op = simple[$urandom_range(0, 5)]; a = $urandom; b = $urandom;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                model(op, a, b, er, eh, edz, eill, elat);
                qr.push_back(er);
                op = simple[$urandom_range(0, 5)]; a = $urandom; b = $urandom;
            end
            if (out_valid) begin
                nres++;
                exp_r = (qr.size() > 0) ? qr.pop_front() : ~result;
                n_cmp++;
                if (result !== exp_r || prev_vld) begin
                    n_err++; $display("FAIL b2b_result%0d: got %h (prev_vld=%b) want %h", nres, result, prev_vld, exp_r);
                end
            end
            prev_vld = out_valid;
        end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1; out_ready = 1'b0;
        n_cmp++;
        if (nres !== 10) begin n_err++; $display("FAIL b2b_count: got %0d results want 10", nres); end
    endtask

    task automatic test_abort();
        int lat;
        bit seen;
        // Abort during BUSY.
        @(negedge clk); op = 4'b1000; a = 32'hDEAD_BEEF; b = 32'h1234_5678; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        n_cmp++;
        if ({out_valid, result} !== {1'b0, 32'd0}) begin
            n_err++; $display("FAIL abort_busy: got vld=%b res=%h want 0/0", out_valid, result);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (W + 5) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        n_cmp++;
        if (seen) begin n_err++; $display("FAIL abort_busy_no_result: got out_valid=1 want 0"); end
        // Abort while holding a result in DONE.
        do_op(4'b0010, 32'd3, 32'd4, 1'b0, lat);
        #2; rst_n = 1'b0; #1;
        n_cmp++;
        if ({out_valid, result} !== {1'b0, 32'd0}) begin
            n_err++; $display("FAIL abort_done: got vld=%b res=%h want 0/0", out_valid, result);
        end
        @(negedge clk); rst_n = 1'b1;
        do_op(4'b1111, 32'h5555_AAAA, 32'h0F0F_0F0F, 1'b0, lat);
        n_cmp++;
        if ({lat, illegal, result, result_hi, zout, dz} !== {32'd1, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL abort_then_illegal: got lat=%0d ill=%b res=%h hi=%h z=%b dz=%b want 1/1/0/0/1/0",
                     lat, illegal, result, result_hi, zout, dz);
        end
        drain();
    endtask

    task automatic test_random();
        logic [3:0] legal [8];
        logic [3:0] o;
        logic [W-1:0] x, y, er, eh;
        logic edz, eill;
        int elat, lat, k;
        legal = '{4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0001, 4'b0100, 4'b1000, 4'b1001};
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 8);
            o = (k == 8) ? 4'($urandom_range(10, 15)) : legal[k];
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            model(o, x, y, er, eh, edz, eill, elat);
            do_op(o, x, y, 1'b1, lat);
            n_cmp++;
            if (lat !== elat) begin
                n_err++; $display("FAIL rnd%0d_latency op=%b: got %0d want %0d", i, o, lat, elat);
            end
            n_cmp++;
            if ({result, result_hi, dz, illegal, zout} !== {er, eh, edz, eill, (er == 0)}) begin
                n_err++;
                $display("FAIL rnd%0d_result op=%b a=%h b=%h: got res=%h hi=%h dz=%b ill=%b z=%b want res=%h hi=%h dz=%b ill=%b z=%b",
                         i, o, x, y, result, result_hi, dz, illegal, zout, er, eh, edz, eill, (er == 0));
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            n_cmp++;
            if ({out_valid, result, result_hi} !== {1'b1, er, eh}) begin
                n_err++; $display("FAIL rnd%0d_stable: got vld=%b res=%h hi=%h want 1/%h/%h", i, out_valid, result, result_hi, er, eh);
            end
            drain();
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL rnd%0d_single_pulse: got vld=%b want 0", i, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
        $fatal(1, "watchdog");
    end

endmodule
